// File: rtl/wave_ramp_gen.sv
// rtl/wave_ramp_gen.sv - tick-paced ramp source (one-shot, sawtooth, triangle) feeding the PDM core
// Optional start_val input enabled by defining WAVE_RAMP_START_VAL_EN.
module wave_ramp_gen #(
  parameter int WIDTH  = 10,
  parameter int DIV_W  = 28,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  input  logic [STEP_W-1:0] step,
`ifdef WAVE_RAMP_START_VAL_EN
  input  logic [WIDTH-1:0]  start_val,
`endif
  output logic [WIDTH-1:0]  out_wave,
  output logic              out_valid,
  output logic              done
);

  localparam logic [WIDTH:0] MAX = {1'b0, {WIDTH{1'b1}}};
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_SAW     = 2'd1;
  localparam logic [1:0] MODE_TRI     = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] wave_n;
  logic             valid_n;
  logic             dir, dir_n;
  logic [1:0]       mode_q, mode_n;
  logic [WIDTH-1:0] start_value;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   sum;

`ifdef WAVE_RAMP_START_VAL_EN
  assign start_value = start_val;
`else
  assign start_value = '0;
`endif

  // One extra bit so the saturation compare sees the carry.
  assign step_ext = (WIDTH+1)'(step);
  assign sum      = {1'b0, out_wave} + step_ext;
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_wave  <= '0;
      out_valid <= 1'b0;
      dir       <= 1'b0;
      mode_q    <= 2'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      out_wave  <= wave_n;
      out_valid <= valid_n;
      dir       <= dir_n;
      mode_q    <= mode_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wave_n  = out_wave;
    valid_n = 1'b0;
    dir_n   = dir;
    mode_n  = mode_q;
    if (restart) begin
      state_n = S_RUN;
      cnt_n   = '0;
      wave_n  = start_value;
      dir_n   = 1'b0;
      mode_n  = mode;
    end else if (state == S_RUN && en) begin
      // >= rather than == so a live div reduction below the count ticks at once.
      if (cnt >= div) begin
        cnt_n   = '0;
        valid_n = 1'b1;
        case (mode_q)
          MODE_ONESHOT: begin
            if (sum >= MAX) begin
              wave_n  = MAX[WIDTH-1:0];
              state_n = S_DONE;
            end else begin
              wave_n = sum[WIDTH-1:0];
            end
          end
          MODE_SAW: wave_n = sum[WIDTH-1:0];
          MODE_TRI: begin
            if (!dir) begin
              if (sum >= MAX) begin
                wave_n = MAX[WIDTH-1:0];
                dir_n  = 1'b1;
              end else begin
                wave_n = sum[WIDTH-1:0];
              end
            end else if ({1'b0, out_wave} <= step_ext) begin
              wave_n = '0;
              dir_n  = 1'b0;
            end else begin
              wave_n = out_wave - WIDTH'(step);
            end
          end
          default: wave_n = out_wave;
        endcase
      end else begin
        cnt_n = cnt + DIV_W'(1);
      end
    end
  end

endmodule
